// File: rtl/mem_b_to_a_ctrl_pkg.sv
// Shared constants for the memory B to memory A return-path controller.
package mem_b_to_a_ctrl_pkg;

  localparam int unsigned DEF_WORDS    = 8;
  localparam int unsigned DEF_CNT_BITS = 3;

  // Cycles spent in READ waiting for memory B data to settle.
  localparam int unsigned READ_SETTLE = 1;

  // One-hot state bit indices.
  localparam int unsigned N_STATES = 7;
  localparam int unsigned I_IDLE   = 0;
  localparam int unsigned I_CLR    = 1;
  localparam int unsigned I_READ   = 2;
  localparam int unsigned I_WRITE  = 3;
  localparam int unsigned I_ADV    = 4;
  localparam int unsigned I_DONE   = 5;
  localparam int unsigned I_ABRT   = 6;

  typedef enum logic [N_STATES-1:0] {
    S_IDLE  = 7'(1 << I_IDLE),
    S_CLR   = 7'(1 << I_CLR),
    S_READ  = 7'(1 << I_READ),
    S_WRITE = 7'(1 << I_WRITE),
    S_ADV   = 7'(1 << I_ADV),
    S_DONE  = 7'(1 << I_DONE),
    S_ABRT  = 7'(1 << I_ABRT)
  } state_t;

  // Start edge to Done pulse latency for a full transfer of the given size.
  function automatic int unsigned xfer_latency(input int unsigned words);
    return words * (READ_SETTLE + 2) + 2;
  endfunction

endpackage

// File: rtl/mem_b_to_a_ctrl_cnt.sv
// Word counter: async reset, sync clear, load, sequence restart and enable.
module mem_b_to_a_ctrl_cnt #(
  parameter int unsigned COUNT_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ld,
  input  logic [COUNT_BITS-1:0] ld_val,
  input  logic                  start_seq,
  output logic [COUNT_BITS-1:0] count
);

  // Count register; clear wins over load, load over restart, restart over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (rst) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (start_seq) begin
      count <= '0;
    end else if (en) begin
      count <= count + COUNT_BITS'(1);
    end
  end

endmodule

// File: rtl/mem_b_to_a_ctrl.sv
// Return-path controller: copies WORDS words from memory B into memory A.
module mem_b_to_a_ctrl
  import mem_b_to_a_ctrl_pkg::*;
#(
  parameter int unsigned WORDS    = DEF_WORDS,
  parameter int unsigned CNT_BITS = DEF_CNT_BITS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic Abort,
  output logic ClrA,
  output logic ClrB,
  output logic IncA,
  output logic IncB,
  output logic WEA,
  output logic Busy,
  output logic Done,
  output logic Aborted
);

  state_t              state;
  state_t              state_nx;
  logic [CNT_BITS-1:0] count;
  logic                last_c;

  assign last_c = (count == CNT_BITS'(WORDS - 1));

  // Word index; cleared while in CLR, stepped in ADV unless this was the last word.
  mem_b_to_a_ctrl_cnt #(
    .COUNT_BITS(CNT_BITS)
  ) u_cnt (
    .clk      (Clk),
    .rst_n    (Reset),
    .rst      (state[I_CLR]),
    .en       (state[I_ADV] & ~last_c),
    .ld       (1'b0),
    .ld_val   ('0),
    .start_seq(1'b0),
    .count    (count)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; Abort beats every other exit from CLR/READ/WRITE/ADV.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (Start) state_nx = S_CLR;
      S_CLR:   state_nx = Abort ? S_ABRT : S_READ;
      S_READ:  state_nx = Abort ? S_ABRT : S_WRITE;
      S_WRITE: state_nx = Abort ? S_ABRT : S_ADV;
      S_ADV: begin
        if (Abort)       state_nx = S_ABRT;
        else if (last_c) state_nx = S_DONE;
        else             state_nx = S_READ;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ABRT:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Each output is a single state flop, so nothing glitches.
  assign ClrA    = state[I_CLR];
  assign ClrB    = state[I_CLR];
  assign WEA     = state[I_WRITE];
  assign IncA    = state[I_ADV];
  assign IncB    = state[I_ADV];
  assign Done    = state[I_DONE];
  assign Aborted = state[I_ABRT];
  assign Busy    = ~state[I_IDLE];

endmodule

// File: tb/tb_mem_b_to_a_ctrl.sv
// Bench for mem_b_to_a_ctrl: a WORDS=8 instance with a memory datapath and a WORDS=1 instance.
`timescale 1ns/1ps
module tb_mem_b_to_a_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, abort0, start1, abort1;
  logic clra0, clrb0, inca0, incb0, wea0, busy0, done0, abrt0;
  logic clra1, clrb1, inca1, incb1, wea1, busy1, done1, abrt1;
  logic [7:0] o0, o1;

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];
  logic [7:0] exp_a [8];
  logic [2:0] addr_a, addr_b;

  int total = 0;
  int bad   = 0;
  int m0_off = 0;
  int m1_off = 0;
  bit m0_ab  = 1'b0;
  bit m1_ab  = 1'b0;
  int ab_at;

  always #5 clk = ~clk;

  assign o0 = {clra0, clrb0, inca0, incb0, wea0, busy0, done0, abrt0};
  assign o1 = {clra1, clrb1, inca1, incb1, wea1, busy1, done1, abrt1};

  mem_b_to_a_ctrl #(.WORDS(8), .CNT_BITS(3)) u_dut8 (
    .Clk(clk), .Reset(rst_n), .Start(start0), .Abort(abort0),
    .ClrA(clra0), .ClrB(clrb0), .IncA(inca0), .IncB(incb0),
    .WEA(wea0), .Busy(busy0), .Done(done0), .Aborted(abrt0)
  );

  mem_b_to_a_ctrl #(.WORDS(1), .CNT_BITS(1)) u_dut1 (
    .Clk(clk), .Reset(rst_n), .Start(start1), .Abort(abort1),
    .ClrA(clra1), .ClrB(clrb1), .IncA(inca1), .IncB(incb1),
    .WEA(wea1), .Busy(busy1), .Done(done1), .Aborted(abrt1)
  );

  // Address counters driven by the controller outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a <= '0;
      addr_b <= '0;
    end else begin
      if (clra0)      addr_a <= '0;
      else if (inca0) addr_a <= addr_a + 3'd1;
      if (clrb0)      addr_b <= '0;
      else if (incb0) addr_b <= addr_b + 3'd1;
    end
  end

  // Memory A write port, data from memory B.
  always_ff @(posedge clk) begin
    if (wea0) mem_a[addr_a] <= mem_b[addr_b];
  end

  // Expected outputs from the cycle offset since the Start edge (0 = idle).
  function automatic logic [7:0] exp_out(input int off, input bit ab, input int w);
    logic clr, wea, inc, done, busy;
    clr  = (off == 1);
    wea  = (off >= 3) && (off <= 3 * w) && (off % 3 == 0);
    inc  = (off >= 4) && (off <= 3 * w + 1) && (off % 3 == 1);
    done = (off == 3 * w + 2);
    busy = (off != 0) || ab;
    return {clr, clr, inc, inc, wea, busy, done, ab};
  endfunction

  // Advance the offset model by one edge.
  function automatic void nxt(input int off, input bit ab, input bit st, input bit abt,
                              input int w, output int noff, output bit nab);
    noff = off;
    nab  = 1'b0;
    if (ab)                  noff = 0;
    else if (off == 0)       noff = st ? 1 : 0;
    else if (off == 3*w + 2) noff = 0;
    else if (abt) begin
      noff = 0;
      nab  = 1'b1;
    end else                 noff = off + 1;
  endfunction

  task automatic step();
    logic [7:0] e0, e1;
    int n;
    bit a;
    @(posedge clk);
    e0 = exp_out(m0_off, m0_ab, 8);
    if (rst_n && e0[3]) exp_a[(m0_off - 3) / 3] = mem_b[(m0_off - 3) / 3];
    nxt(m0_off, m0_ab, start0, abort0, 8, n, a);
    m0_off = n; m0_ab = a;
    nxt(m1_off, m1_ab, start1, abort1, 1, n, a);
    m1_off = n; m1_ab = a;
    if (!rst_n) begin
      m0_off = 0; m0_ab = 1'b0; m1_off = 0; m1_ab = 1'b0;
    end
    #1;
    e0 = exp_out(m0_off, m0_ab, 8);
    e1 = exp_out(m1_off, m1_ab, 1);
    total++;
    assert (o0 === e0) else begin
      bad++;
      $error("FAIL out_w8 t=%0t got=%b exp=%b", $time, o0, e0);
    end
    total++;
    assert (o1 === e1) else begin
      bad++;
      $error("FAIL out_w1 t=%0t got=%b exp=%b", $time, o1, e1);
    end
  endtask

  task automatic check_zero();
    total++;
    assert (o0 === 8'h00) else begin
      bad++;
      $error("FAIL rst_w8 t=%0t got=%b exp=%b", $time, o0, 8'h00);
    end
    total++;
    assert (o1 === 8'h00) else begin
      bad++;
      $error("FAIL rst_w1 t=%0t got=%b exp=%b", $time, o1, 8'h00);
    end
  endtask

  task automatic check_a();
    for (int i = 0; i < 8; i++) begin
      total++;
      assert (mem_a[i] === exp_a[i]) else begin
        bad++;
        $error("FAIL mem_a[%0d] got=%h exp=%h", i, mem_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic run_until_idle();
    for (int c = 0; c < 40 && (m0_off != 0 || m0_ab); c++) step();
    step();
  endtask

  initial begin
    rst_n = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_b[i] = 8'(17 * (i + 1));
      exp_a[i] = 8'h00;
    end

    // Reset for two cycles, then idle with stray Abort pulses.
    #2 rst_n = 1'b0;
    #1 check_zero();
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      abort0 = 1'($urandom_range(0, 1));
      abort1 = 1'($urandom_range(0, 1));
      step();
    end
    abort0 = 1'b0; abort1 = 1'b0;

    // Full transfer of 0x11..0x88.
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    run_until_idle();
    check_a();

    // Start held high: back-to-back transfers with one IDLE cycle between.
    for (int i = 0; i < 8; i++) mem_b[i] = 8'($urandom);
    start0 = 1'b1;
    for (int c = 0; c < 40; c++) step();
    start0 = 1'b0;
    run_until_idle();
    check_a();

    // Abort during the second write: words 0 and 1 land, the rest stay put.
    for (int i = 0; i < 8; i++) mem_b[i] = 8'($urandom);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 0; c < 10 && m0_off != 6; c++) step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    run_until_idle();
    check_a();

    // Random transfers with a random abort point (some land in DONE or never).
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) mem_b[i] = 8'($urandom);
      ab_at  = int'($urandom_range(1, 32));
      start0 = 1'b1;
      for (int w = int'($urandom_range(1, 2)); w > 0; w--) step();
      start0 = 1'b0;
      for (int c = 0; c < 32; c++) begin
        abort0 = (m0_off == ab_at) ||
                 (m0_off == 0 && !m0_ab && $urandom_range(0, 3) == 0);
        step();
      end
      abort0 = 1'b0;
      run_until_idle();
      check_a();
    end

    // Reset during a READ, then a clean restart from address 0.
    for (int i = 0; i < 8; i++) mem_b[i] = 8'($urandom);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 0; c < 10 && m0_off != 5; c++) step();
    #2 rst_n = 1'b0;
    #1 check_zero();
    m0_off = 0; m0_ab = 1'b0; m1_off = 0; m1_ab = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) mem_b[i] = 8'($urandom);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    run_until_idle();
    check_a();

    // Single-word instance: Start pulses while busy and in DONE are ignored.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 0; c < 10 && m1_off != 5; c++) step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int c = 0; c < 6; c++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
